maze_dfs_engine: RTL and testbench

- Parametrised depth-first maze solver: grid size, stack depth and memory read latency are configurable.
- Owns its coordinate registers, direction counter and path stack, so no external counters or stack are needed.
- Drives an external 1-bit-per-cell maze memory (1 = wall/visited) and marks visited cells by writing 1.
- On success, streams the source-to-destination path over a valid/ready interface; sits between the maze RAM and the path display logic.

---
 rtl/maze_dfs_engine_if.sv | 31 +++
 rtl/maze_dfs_engine.sv | 272 +++++++++++++++++++++++++++
 tb/tb_maze_dfs_engine.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/maze_dfs_engine_if.sv
// Maze RAM bus and path stream shared by the DFS engine,
// the maze memory and the path consumer.
interface maze_dfs_engine_if #(
    parameter int ROW_W = 4,
    parameter int COL_W = 4
) ();
    logic             mem_rd;
    logic             mem_wr;
    logic [ROW_W-1:0] mem_row;
    logic [COL_W-1:0] mem_col;
    logic             mem_rdata;
    logic             path_valid;
    logic             path_ready;
    logic [ROW_W-1:0] path_row;
    logic [COL_W-1:0] path_col;
    logic             path_last;

    modport master (
        output mem_rd, mem_wr, mem_row, mem_col,
        input  mem_rdata,
        output path_valid, path_row, path_col, path_last,
        input  path_ready
    );

    modport slave (
        input  mem_rd, mem_wr, mem_row, mem_col,
        output mem_rdata,
        input  path_valid, path_row, path_col, path_last,
        output path_ready
    );
endinterface

// File: rtl/maze_dfs_engine.sv
// Depth-first maze solver with internal path stack; streams the found path.
// Define MAZE_DIAG_EN for 8-direction moves (default: 4 directions).
module maze_dfs_engine #(
    parameter int ROW_W       = 4,
    parameter int COL_W       = 4,
    parameter int STACK_DEPTH = 256,
    parameter int MEM_LAT     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [ROW_W-1:0]             src_row,
    input  logic [COL_W-1:0]             src_col,
    input  logic [ROW_W-1:0]             dst_row,
    input  logic [COL_W-1:0]             dst_col,
    output logic                         busy,
    output logic [$clog2(STACK_DEPTH):0] path_len,
    output logic                         done,
    output logic                         impossible,
    output logic                         overflow,
    maze_dfs_engine_if.master            bus
);
    localparam int PW = $clog2(STACK_DEPTH) + 1;
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
`ifdef MAZE_DIAG_EN
    localparam int DW = 3;
`else
    localparam int DW = 2;
`endif

    typedef enum logic [3:0] {
        IDLE, RD_SRC, WAIT_SRC, CHECK_DIR, RD_NB, WAIT_NB,
        PUSH, POP, FAIL, FOUND, STREAM, FINISH
    } state_t;

    state_t state;

    // Top bit of a stored dir flags "all directions tried".
    logic [ROW_W-1:0] stk_row [STACK_DEPTH];
    logic [COL_W-1:0] stk_col [STACK_DEPTH];
    logic [DW:0]      stk_dir [STACK_DEPTH];

    logic [PW-1:0]    sp;
    logic [PW-1:0]    idx;
    logic [CW-1:0]    cnt;
    logic [ROW_W-1:0] src_r, dst_r, nb_r;
    logic [COL_W-1:0] src_c, dst_c, nb_c;

    logic [IW-1:0]    top;
    logic [ROW_W-1:0] cur_row, nb_row;
    logic [COL_W-1:0] cur_col, nb_col;
    logic [DW:0]      cur_dir;
    logic             go_up, go_dn, go_lf, go_rt;
    logic             nb_oob;
    logic [PW-1:0]    nxt_idx;
    logic             nxt_last;

    assign top     = IW'(sp - PW'(1));
    assign cur_row = stk_row[top];
    assign cur_col = stk_col[top];
    assign cur_dir = stk_dir[top];

    assign nxt_idx  = idx + PW'(1);
    assign nxt_last = (nxt_idx == sp - PW'(1));

    // Decode the current direction into per-axis moves.
    always_comb begin
        go_up = 1'b0;
        go_dn = 1'b0;
        go_lf = 1'b0;
        go_rt = 1'b0;
`ifdef MAZE_DIAG_EN
        case (cur_dir[2:0])
            3'd0: go_up = 1'b1;
            3'd1: begin go_up = 1'b1; go_rt = 1'b1; end
            3'd2: go_rt = 1'b1;
            3'd3: begin go_dn = 1'b1; go_rt = 1'b1; end
            3'd4: go_dn = 1'b1;
            3'd5: begin go_dn = 1'b1; go_lf = 1'b1; end
            3'd6: go_lf = 1'b1;
            default: begin go_up = 1'b1; go_lf = 1'b1; end
        endcase
`else
        case (cur_dir[1:0])
            2'd0:    go_up = 1'b1;
            2'd1:    go_rt = 1'b1;
            2'd2:    go_dn = 1'b1;
            default: go_lf = 1'b1;
        endcase
`endif
    end

    assign nb_oob = (go_up && cur_row == '0) || (go_dn && cur_row == '1) ||
                    (go_lf && cur_col == '0) || (go_rt && cur_col == '1);

    assign nb_row = go_up ? cur_row - ROW_W'(1) :
                    go_dn ? cur_row + ROW_W'(1) : cur_row;
    assign nb_col = go_lf ? cur_col - COL_W'(1) :
                    go_rt ? cur_col + COL_W'(1) : cur_col;

    // Solver FSM: search, stack maintenance and path streaming.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            sp             <= '0;
            idx            <= '0;
            cnt            <= '0;
            src_r          <= '0;
            src_c          <= '0;
            dst_r          <= '0;
            dst_c          <= '0;
            nb_r           <= '0;
            nb_c           <= '0;
            busy           <= 1'b0;
            path_len       <= '0;
            done           <= 1'b0;
            impossible     <= 1'b0;
            overflow       <= 1'b0;
            bus.mem_rd     <= 1'b0;
            bus.mem_wr     <= 1'b0;
            bus.mem_row    <= '0;
            bus.mem_col    <= '0;
            bus.path_valid <= 1'b0;
            bus.path_row   <= '0;
            bus.path_col   <= '0;
            bus.path_last  <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stk_row[i] <= '0;
                stk_col[i] <= '0;
                stk_dir[i] <= '0;
            end
        end else begin
            bus.mem_rd <= 1'b0;
            bus.mem_wr <= 1'b0;
            done       <= 1'b0;
            impossible <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        src_r       <= src_row;
                        src_c       <= src_col;
                        dst_r       <= dst_row;
                        dst_c       <= dst_col;
                        overflow    <= 1'b0;
                        path_len    <= '0;
                        sp          <= '0;
                        busy        <= 1'b1;
                        bus.mem_rd  <= 1'b1;
                        bus.mem_row <= src_row;
                        bus.mem_col <= src_col;
                        state       <= RD_SRC;
                    end
                end
                RD_SRC: begin
                    cnt   <= CW'(MEM_LAT - 1);
                    state <= WAIT_SRC;
                end
                WAIT_SRC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (bus.mem_rdata) begin
                        impossible <= 1'b1;
                        state      <= FAIL;
                    end else begin
                        bus.mem_wr <= 1'b1;
                        stk_row[0] <= src_r;
                        stk_col[0] <= src_c;
                        stk_dir[0] <= '0;
                        sp         <= PW'(1);
                        if (src_r == dst_r && src_c == dst_c)
                            state <= FOUND;
                        else
                            state <= CHECK_DIR;
                    end
                end
                CHECK_DIR: begin
                    if (cur_dir[DW]) begin
                        state <= POP;
                    end else if (nb_oob) begin
                        stk_dir[top] <= cur_dir + 1'b1;
                    end else begin
                        nb_r        <= nb_row;
                        nb_c        <= nb_col;
                        bus.mem_rd  <= 1'b1;
                        bus.mem_row <= nb_row;
                        bus.mem_col <= nb_col;
                        state       <= RD_NB;
                    end
                end
                RD_NB: begin
                    cnt   <= CW'(MEM_LAT - 1);
                    state <= WAIT_NB;
                end
                WAIT_NB: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        stk_dir[top] <= cur_dir + 1'b1;
                        state <= bus.mem_rdata ? CHECK_DIR : PUSH;
                    end
                end
                PUSH: begin
                    if (sp == PW'(STACK_DEPTH)) begin
                        overflow   <= 1'b1;
                        impossible <= 1'b1;
                        state      <= FAIL;
                    end else begin
                        bus.mem_wr      <= 1'b1;
                        bus.mem_row     <= nb_r;
                        bus.mem_col     <= nb_c;
                        stk_row[IW'(sp)] <= nb_r;
                        stk_col[IW'(sp)] <= nb_c;
                        stk_dir[IW'(sp)] <= '0;
                        sp              <= sp + PW'(1);
                        if (nb_r == dst_r && nb_c == dst_c)
                            state <= FOUND;
                        else
                            state <= CHECK_DIR;
                    end
                end
                POP: begin
                    sp <= sp - PW'(1);
                    if (sp == PW'(1)) begin
                        impossible <= 1'b1;
                        state      <= FAIL;
                    end else begin
                        state <= CHECK_DIR;
                    end
                end
                FAIL: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                FOUND: begin
                    path_len       <= sp;
                    idx            <= '0;
                    bus.path_valid <= 1'b1;
                    bus.path_row   <= stk_row[0];
                    bus.path_col   <= stk_col[0];
                    bus.path_last  <= (sp == PW'(1));
                    state          <= STREAM;
                end
                STREAM: begin
                    if (bus.path_ready) begin
                        if (bus.path_last) begin
                            bus.path_valid <= 1'b0;
                            bus.path_last  <= 1'b0;
                            bus.path_row   <= '0;
                            bus.path_col   <= '0;
                            done           <= 1'b1;
                            state          <= FINISH;
                        end else begin
                            idx           <= nxt_idx;
                            bus.path_row  <= stk_row[IW'(nxt_idx)];
                            bus.path_col  <= stk_col[IW'(nxt_idx)];
                            bus.path_last <= nxt_last;
                        end
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_maze_dfs_engine.sv
// Randomised bench for maze_dfs_engine: two instances (deep and
// shallow stack) on a 4x4 grid, checked against a DFS reference model.
module tb_maze_dfs_engine;
    localparam int RW   = 2;
    localparam int CW   = 2;
    localparam int LAT  = 2;
    localparam int DEP0 = 16;
    localparam int DEP1 = 3;
    localparam int N    = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic          start [2];
    logic [RW-1:0] s_r [2];
    logic [CW-1:0] s_c [2];
    logic [RW-1:0] d_r [2];
    logic [CW-1:0] d_c [2];
    logic          rdy [2];
    logic          clr [2];
    logic [N-1:0]  wall [2];

    logic          busy [2];
    logic          done [2];
    logic          imp [2];
    logic          ovf [2];
    logic [7:0]    plen [2];
    logic          mrd [2];
    logic          mwr [2];
    logic [RW-1:0] mrow [2];
    logic [CW-1:0] mcol [2];
    logic          pv [2];
    logic          plast [2];
    logic [RW-1:0] prow [2];
    logic [CW-1:0] pcol [2];
    int            rd_cnt [2];
    int            wr_cnt [2];
    int            both_cnt [2];

    for (genvar g = 0; g < 2; g++) begin : gu
        localparam int DEP = (g == 0) ? DEP0 : DEP1;
        localparam int PW  = $clog2(DEP) + 1;

        maze_dfs_engine_if #(.ROW_W(RW), .COL_W(CW)) mif ();

        logic [PW-1:0]  len;
        logic [N-1:0]   vis;
        logic [LAT-1:0] sh;
        logic [3:0]     a;
        int             nrd, nwr, nboth;

        maze_dfs_engine #(
            .ROW_W(RW), .COL_W(CW), .STACK_DEPTH(DEP), .MEM_LAT(LAT)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start[g]),
            .src_row   (s_r[g]),
            .src_col   (s_c[g]),
            .dst_row   (d_r[g]),
            .dst_col   (d_c[g]),
            .busy      (busy[g]),
            .path_len  (len),
            .done      (done[g]),
            .impossible(imp[g]),
            .overflow  (ovf[g]),
            .bus       (mif.master)
        );

        assign a              = {mif.mem_row, mif.mem_col};
        assign mif.mem_rdata  = sh[LAT-1];
        assign mif.path_ready = rdy[g];

        // Maze RAM: wall map ORed with visited marks, fixed read latency.
        always @(posedge clk) begin
            if (clr[g]) begin
                vis   <= '0;
                sh    <= '1;
                nrd   <= 0;
                nwr   <= 0;
                nboth <= 0;
            end else begin
                sh[0] <= mif.mem_rd ? (wall[g][a] | vis[a]) : 1'b1;
                for (int i = 1; i < LAT; i++) sh[i] <= sh[i-1];
                if (mif.mem_rd) nrd <= nrd + 1;
                if (mif.mem_wr) begin
                    nwr    <= nwr + 1;
                    vis[a] <= 1'b1;
                end
                if (mif.mem_rd && mif.mem_wr) nboth <= nboth + 1;
            end
        end

        assign plen[g]     = 8'(len);
        assign mrd[g]      = mif.mem_rd;
        assign mwr[g]      = mif.mem_wr;
        assign mrow[g]     = mif.mem_row;
        assign mcol[g]     = mif.mem_col;
        assign pv[g]       = mif.path_valid;
        assign plast[g]    = mif.path_last;
        assign prow[g]     = mif.path_row;
        assign pcol[g]     = mif.path_col;
        assign rd_cnt[g]   = nrd;
        assign wr_cnt[g]   = nwr;
        assign both_cnt[g] = nboth;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference DFS: 0 = found, 1 = no path, 2 = stack overflow.
    int exp_kind;
    int exp_r[$];
    int exp_c[$];
    int exp_rd;
    int exp_wr;

    task automatic model(input int u, input int sr, input int sc,
                         input int dr, input int dc);
        int dy[4] = '{-1, 0, 1, 0};
        int dx[4] = '{0, 1, 0, -1};
        bit seen[N];
        int qr[$];
        int qc[$];
        int qd[$];
        int dep, t, nr, nc;
        dep = (u == 0) ? DEP0 : DEP1;
        exp_r.delete();
        exp_c.delete();
        for (int i = 0; i < N; i++) seen[i] = wall[u][i];
        exp_rd = 1;
        exp_wr = 0;
        if (seen[sr*4+sc]) begin
            exp_kind = 1;
            return;
        end
        seen[sr*4+sc] = 1'b1;
        exp_wr = 1;
        qr.push_back(sr);
        qc.push_back(sc);
        qd.push_back(0);
        if (sr == dr && sc == dc) begin
            exp_kind = 0;
            exp_r = qr;
            exp_c = qc;
            return;
        end
        while (1) begin
            t = qr.size() - 1;
            if (qd[t] >= 4) begin
                void'(qr.pop_back());
                void'(qc.pop_back());
                void'(qd.pop_back());
                if (qr.size() == 0) begin
                    exp_kind = 1;
                    return;
                end
                continue;
            end
            nr = qr[t] + dy[qd[t]];
            nc = qc[t] + dx[qd[t]];
            qd[t] = qd[t] + 1;
            if (nr < 0 || nr > 3 || nc < 0 || nc > 3) continue;
            exp_rd++;
            if (seen[nr*4+nc]) continue;
            if (qr.size() == dep) begin
                exp_kind = 2;
                return;
            end
            seen[nr*4+nc] = 1'b1;
            exp_wr++;
            qr.push_back(nr);
            qc.push_back(nc);
            qd.push_back(0);
            if (nr == dr && nc == dc) begin
                exp_kind = 0;
                exp_r = qr;
                exp_c = qc;
                return;
            end
        end
    endtask

    // One solve: mode 0 ready high, 1 ready toggling, 2 ready random.
    task automatic run(input int u, input int sr, input int sc,
                       input int dr, input int dc, input int mode,
                       input bit chk_imp_at);
        int k, got, ndone, nimp, imp_at, nbad, elen;
        logic [4:0] hold;
        bit stalled, fin;
        model(u, sr, sc, dr, dc);
        elen = (exp_kind == 0) ? exp_r.size() : 0;
        @(negedge clk);
        clr[u] = 1'b1;
        @(negedge clk);
        clr[u] = 1'b0;
        s_r[u] = RW'(sr);
        s_c[u] = CW'(sc);
        d_r[u] = RW'(dr);
        d_c[u] = CW'(dc);
        rdy[u] = 1'b1;
        start[u] = 1'b1;
        @(negedge clk);
        start[u] = 1'b0;
        k = 1; got = 0; ndone = 0; nimp = 0; imp_at = 0; nbad = 0;
        stalled = 1'b0; fin = 1'b0; hold = '0;
        while (!fin && k < 3000) begin
            case (mode)
                0:       rdy[u] = 1'b1;
                1:       rdy[u] = k[0];
                default: rdy[u] = 1'($urandom_range(0, 1));
            endcase
            if (done[u]) ndone++;
            if (imp[u]) begin
                nimp++;
                imp_at = k;
            end
            if (stalled && (!pv[u] || {prow[u], pcol[u], plast[u]} != hold))
                nbad++;
            stalled = 1'b0;
            if (pv[u]) begin
                if (rdy[u]) begin
                    if (got < elen) begin
                        check("path_row", 32'(prow[u]), 32'(exp_r[got]));
                        check("path_col", 32'(pcol[u]), 32'(exp_c[got]));
                        check("path_last", 32'(plast[u]), 32'(got == elen - 1));
                    end else begin
                        check("path_extra", got + 1, elen);
                    end
                    got++;
                end else begin
                    stalled = 1'b1;
                    hold = {prow[u], pcol[u], plast[u]};
                end
            end
            if (!busy[u]) fin = 1'b1;
            k++;
            @(negedge clk);
        end
        check("timeout", 32'(fin), 1);
        check("done_cnt", ndone, 32'(exp_kind == 0));
        check("imp_cnt", nimp, 32'(exp_kind != 0));
        check("overflow", 32'(ovf[u]), 32'(exp_kind == 2));
        check("n_path", got, elen);
        check("path_len", 32'(plen[u]), elen);
        check("stall_hold", nbad, 0);
        check("rd_cnt", rd_cnt[u], exp_rd);
        check("wr_cnt", wr_cnt[u], exp_wr);
        check("rd_wr_both", both_cnt[u], 0);
        if (chk_imp_at) check("imp_cycle", imp_at, LAT + 2);
    endtask

    task automatic check_zero(input int u, input string tag);
        check({tag, "_flags"},
              32'({busy[u], pv[u], plast[u], done[u], imp[u], ovf[u],
                   mrd[u], mwr[u]}), 0);
        check({tag, "_len"}, 32'(plen[u]), 0);
        check({tag, "_bus"}, 32'({prow[u], pcol[u], mrow[u], mcol[u]}), 0);
    endtask

    initial begin
        int w;
        bit seen_pv;
        for (int u = 0; u < 2; u++) begin
            start[u] = 1'b0;
            s_r[u] = '0; s_c[u] = '0; d_r[u] = '0; d_c[u] = '0;
            rdy[u] = 1'b1;
            clr[u] = 1'b1;
            wall[u] = '0;
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_zero(0, "rst0");
        check_zero(1, "rst1");
        rst = 1'b1;
        @(negedge clk);
        clr[0] = 1'b0;
        clr[1] = 1'b0;

        wall[0] = '0;
        run(0, 0, 0, 0, 3, 0, 1'b0);

        wall[0] = 16'(1 << 5);
        run(0, 1, 1, 2, 2, 0, 1'b1);

        wall[0] = '0;
        run(0, 2, 2, 2, 2, 0, 1'b0);

        wall[0] = 16'((1 << 2) | (1 << 5));
        run(0, 0, 0, 2, 0, 0, 1'b0);

        wall[1] = ~16'h008F;
        run(1, 0, 0, 1, 3, 0, 1'b0);
        run(1, 0, 0, 0, 0, 0, 1'b0);

        wall[0] = '0;
        run(0, 0, 0, 3, 0, 1, 1'b0);

        for (int i = 0; i < 30; i++) begin
            wall[0] = 16'($urandom & $urandom);
            run(0, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 2), 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            w = $urandom_range(0, 1) ? int'($urandom & $urandom) : int'($urandom);
            wall[1] = 16'(w);
            run(1, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 2), 1'b0);
        end

        wall[0] = '0;
        @(negedge clk);
        clr[0] = 1'b1;
        @(negedge clk);
        clr[0] = 1'b0;
        s_r[0] = 2'd0; s_c[0] = 2'd0; d_r[0] = 2'd3; d_c[0] = 2'd3;
        rdy[0] = 1'b0;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        seen_pv = 1'b0;
        for (int k = 0; k < 1000 && !seen_pv; k++) begin
            if (pv[0]) seen_pv = 1'b1;
            else @(negedge clk);
        end
        check("stream_reached", 32'(seen_pv), 1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check_zero(0, "midrst");
        @(negedge clk);
        rst = 1'b1;
        rdy[0] = 1'b1;
        wall[0] = 16'((1 << 2) | (1 << 5));
        run(0, 0, 0, 2, 0, 2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
